// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard
//   Tracks DEPTH in-flight register writes (slot 0 youngest, slot DEPTH-1
//   oldest). Forwards the youngest matching ready result to two source
//   operands, stalls on load-use hazards and on an unfilled load reaching
//   the oldest slot, and retires entries in order to the RF write port.
//   Optional build macro: FWD_ZERO_REG_EN makes r0 a hard zero. When it is
//   defined, r0 is never tracked, never matched and always reads as 0.
module fwd_scoreboard #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 3,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic              issue_we,
  input  logic              issue_load,
  input  logic [REG_AW-1:0] issue_rd,
  input  logic [DATA_W-1:0] issue_data,
  input  logic [REG_AW-1:0] rs_a,
  input  logic [REG_AW-1:0] rs_b,
  input  logic [DATA_W-1:0] rf_a,
  input  logic [DATA_W-1:0] rf_b,
  output logic [DATA_W-1:0] fwd_a,
  output logic [DATA_W-1:0] fwd_b,
  output logic              stall,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              wb_valid,
  output logic [REG_AW-1:0] wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              ld_err
);

  // slot storage
  logic [DEPTH-1:0]  v_q, v_d;
  logic [DEPTH-1:0]  rdy_q, rdy_d;
  logic [REG_AW-1:0] rd_q   [DEPTH];
  logic [REG_AW-1:0] rd_d   [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];

  // retire port and error flag
  logic              wb_valid_q, wb_valid_d;
  logic [REG_AW-1:0] wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              ld_err_q, ld_err_d;

  // lookup results
  logic              hit_a, hit_rdy_a, hit_b, hit_rdy_b;
  logic [DATA_W-1:0] hit_data_a, hit_data_b;
  logic              hazard, retire_block;
  logic              zero_a, zero_b, rd_zero;

  // oldest unfilled load
  logic              pend;
  int                pend_idx;
  int                fill_idx;

`ifdef FWD_ZERO_REG_EN
  assign zero_a  = (rs_a == '0);
  assign zero_b  = (rs_b == '0);
  assign rd_zero = (issue_rd == '0);
`else
  assign zero_a  = 1'b0;
  assign zero_b  = 1'b0;
  assign rd_zero = 1'b0;
`endif

  // Youngest-first match: scan oldest to youngest so the youngest hit wins.
  always_comb begin
    hit_a      = 1'b0;
    hit_rdy_a  = 1'b0;
    hit_data_a = '0;
    hit_b      = 1'b0;
    hit_rdy_b  = 1'b0;
    hit_data_b = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (v_q[k] && (rd_q[k] == rs_a) && !zero_a) begin
        hit_a      = 1'b1;
        hit_rdy_a  = rdy_q[k];
        hit_data_a = data_q[k];
      end
      if (v_q[k] && (rd_q[k] == rs_b) && !zero_b) begin
        hit_b      = 1'b1;
        hit_rdy_b  = rdy_q[k];
        hit_data_b = data_q[k];
      end
    end
  end

  assign fwd_a = zero_a ? '0 : ((hit_a && hit_rdy_a) ? hit_data_a : rf_a);
  assign fwd_b = zero_b ? '0 : ((hit_b && hit_rdy_b) ? hit_data_b : rf_b);

  // Only registered ready feeds the stall; a load response is never
  // bypassed in its arrival cycle, so load-use costs at least one cycle.
  assign hazard       = (hit_a && !hit_rdy_a) || (hit_b && !hit_rdy_b);
  assign retire_block = v_q[DEPTH-1] && !rdy_q[DEPTH-1];
  assign stall        = (issue_valid && hazard) || retire_block;
  assign issue_ready  = !stall;

  // Locate the oldest valid slot still waiting for its load data.
  always_comb begin
    pend     = 1'b0;
    pend_idx = 0;
    for (int k = 0; k < DEPTH; k++) begin
      if (v_q[k] && !rdy_q[k]) begin
        pend     = 1'b1;
        pend_idx = k;
      end
    end
  end

  // Slot next-state: shift on advance, then apply a load fill at the
  // entry's post-shift position.
  always_comb begin
    v_d      = v_q;
    rdy_d    = rdy_q;
    rd_d     = rd_q;
    data_d   = data_q;
    fill_idx = pend_idx;
    if (!stall) begin
      v_d[0]    = issue_valid && issue_we && !rd_zero;
      rdy_d[0]  = !issue_load;
      rd_d[0]   = issue_rd;
      data_d[0] = issue_data;
      for (int k = 1; k < DEPTH; k++) begin
        v_d[k]    = v_q[k-1];
        rdy_d[k]  = rdy_q[k-1];
        rd_d[k]   = rd_q[k-1];
        data_d[k] = data_q[k-1];
      end
      // a pending load in the oldest slot forces a stall, so this never
      // points past the end of the array while advancing
      fill_idx = pend_idx + 1;
    end
    if (ld_valid && pend) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (k == fill_idx) begin
          rdy_d[k]  = 1'b1;
          data_d[k] = ld_data;
        end
      end
    end
  end

  // Retire port next-state; fields hold while stalled.
  always_comb begin
    wb_valid_d = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    if (!stall) begin
      wb_valid_d = v_q[DEPTH-1];
      wb_rd_d    = rd_q[DEPTH-1];
      wb_data_d  = data_q[DEPTH-1];
    end
    ld_err_d = ld_err_q || (ld_valid && !pend);
  end

  // State registers; reset discards every in-flight entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q        <= '0;
      rdy_q      <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        rd_q[k]   <= '0;
        data_q[k] <= '0;
      end
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      ld_err_q   <= 1'b0;
    end else begin
      v_q        <= v_d;
      rdy_q      <= rdy_d;
      rd_q       <= rd_d;
      data_q     <= data_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      ld_err_q   <= ld_err_d;
    end
  end

  assign wb_valid = wb_valid_q;
  assign wb_rd    = wb_rd_q;
  assign wb_data  = wb_data_q;
  assign ld_err   = ld_err_q;

endmodule
